// File: rtl/bus_arbiter_if.sv
// Bus bundle between the processor ports, the round-robin arbiter and the shared RAM.
//   port_address  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
//   port_wdata    NUM_PORTS*DATA_W  per-port write data, port i at [i*DATA_W +: DATA_W]
//   port_control  NUM_PORTS*2       per-port {read,write}, port i at [2i+1:2i]
//   port_ready    NUM_PORTS         one-hot completion pulse
//   port_rdata    DATA_W            shared read data, valid while port_ready[i] is high
//   ram_address   ADDR_W            RAM address
//   ram_wdata     DATA_W            RAM write data
//   ram_control   2                 {read,write} strobe to RAM
//   ram_rdata     DATA_W            RAM read data
//   busy          1                 transaction in flight
// Modport slave is the arbiter side; modport master is the cores/RAM side.
interface bus_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS*ADDR_W-1:0] port_address;
    logic [NUM_PORTS*DATA_W-1:0] port_wdata;
    logic [NUM_PORTS*2-1:0]      port_control;
    logic [NUM_PORTS-1:0]        port_ready;
    logic [DATA_W-1:0]           port_rdata;
    logic [ADDR_W-1:0]           ram_address;
    logic [DATA_W-1:0]           ram_wdata;
    logic [1:0]                  ram_control;
    logic [DATA_W-1:0]           ram_rdata;
    logic                        busy;

    modport slave (
        input  port_address, port_wdata, port_control, ram_rdata,
        output port_ready, port_rdata, ram_address, ram_wdata, ram_control, busy
    );

    modport master (
        output port_address, port_wdata, port_control, ram_rdata,
        input  port_ready, port_rdata, ram_address, ram_wdata, ram_control, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving NUM_PORTS processor ports access to one shared RAM.
// One transaction is in flight at a time: IDLE picks a winner, ISSUE strobes the RAM
// for one cycle, WAIT counts out the RAM read latency, DONE pulses the winner's ready.
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  asynchronous active-high reset
//   bus    bus_arbiter_if.slave: per-port requests/ready/rdata and the RAM side
module bus_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(RAM_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state, state_next;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     grant;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 is_read;
    logic [CNT_W-1:0]     count;
    logic [DATA_W-1:0]    rdata_q;
    logic [NUM_PORTS-1:0] ready_vec;

    // Winner of the current scan and the values it presents.
    logic                 found;
    logic [IDX_W-1:0]     winner;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;
    logic                 win_read;
    int                   scan_idx;

    // Scan starts one past the last grant so the previous winner ends up last.
    // A {1,1} request counts as a read: only the read bit decides the direction.
    always_comb begin
        found     = 1'b0;
        winner    = '0;
        win_addr  = '0;
        win_wdata = '0;
        win_read  = 1'b0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan_idx = (int'(last_grant) + k) % NUM_PORTS;
            if (!found && (bus.port_control[2*scan_idx +: 2] != 2'b00)) begin
                found     = 1'b1;
                winner    = IDX_W'(scan_idx);
                win_addr  = bus.port_address[scan_idx*ADDR_W +: ADDR_W];
                win_wdata = bus.port_wdata[scan_idx*DATA_W +: DATA_W];
                win_read  = bus.port_control[2*scan_idx + 1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = ISSUE;
            ISSUE:   state_next = is_read ? WAIT : DONE;
            WAIT:    if (count == CNT_W'(RAM_LATENCY)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction latches: written only at the grant, so port inputs are never
    // re-sampled while a transaction is in flight. The reset value of last_grant
    // gives port 0 top priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= IDX_W'(NUM_PORTS - 1);
            grant      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_read    <= 1'b0;
            count      <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= winner;
                        last_grant <= winner;
                        addr_q     <= win_addr;
                        wdata_q    <= win_wdata;
                        is_read    <= win_read;
                    end
                end
                ISSUE: count <= CNT_W'(1);
                WAIT: begin
                    if (count == CNT_W'(RAM_LATENCY)) begin
                        rdata_q <= bus.ram_rdata;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ready_vec = '0;
        if (state == DONE) ready_vec[grant] = 1'b1;
    end

    // RAM address/data follow the latches, so they hold their last values
    // outside ISSUE; only the strobe is gated by state.
    assign bus.ram_address = addr_q;
    assign bus.ram_wdata   = wdata_q;
    assign bus.ram_control = (state == ISSUE) ? (is_read ? 2'b10 : 2'b01) : 2'b00;
    assign bus.busy        = (state != IDLE);
    assign bus.port_ready  = ready_vec;
    assign bus.port_rdata  = rdata_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_bus_arbiter;
    localparam int N   = 4;
    localparam int AW  = 23;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Port stimulus, packed onto the bus by drive().
    logic [1:0]    ctrl  [N];
    logic [AW-1:0] addr  [N];
    logic [DW-1:0] wdata [N];

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.port_control[2*i +: 2]  = ctrl[i];
            bus.port_address[i*AW +: AW] = addr[i];
            bus.port_wdata[i*DW +: DW]   = wdata[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        if (a == 23'h10) return 32'h1234_5678;
        return ({9'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // RAM: data is valid exactly LAT cycles after the read strobe cycle, garbage otherwise.
    int            rd_cnt  = -1;
    logic [AW-1:0] rd_addr = '0;
    always @(negedge clk) begin
        if (bus.ram_control == 2'b10) begin
            rd_cnt  = LAT;
            rd_addr = bus.ram_address;
        end else if (rd_cnt >= 0) begin
            rd_cnt--;
        end
        bus.ram_rdata = (rd_cnt == 0) ? ram_val(rd_addr) : ~ram_val(rd_addr) ^ 32'h1;
    end

    // Reference model: a transaction is a schedule of offsets from the cycle the
    // winner was chosen (strobe at +1, ready at +2 for writes, +2+LAT for reads).
    bit            m_active = 1'b0;
    int            m_age    = 0;
    int            m_port   = 0;
    bit            m_read   = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    int            m_last   = N - 1;
    logic [DW-1:0] m_rdata  = '0;
    int            grant_log[$];
    logic [N-1:0]  rdy_seen = '0;

    always @(negedge clk) begin
        logic [1:0]   exp_ctrl;
        logic [N-1:0] exp_ready;
        int           ready_at;
        int           p;
        rdy_seen = bus.port_ready;
        if (reset) begin
            m_active = 1'b0;
            m_last   = N - 1;
            m_rdata  = '0;
            check("rst_ctrl",  bus.ram_control, 2'b00);
            check("rst_busy",  bus.busy, 1'b0);
            check("rst_ready", bus.port_ready, '0);
            check("rst_rdata", bus.port_rdata, '0);
            check("rst_addr",  bus.ram_address, '0);
        end else begin
            if (!m_active) begin
                check("idle_ctrl",  bus.ram_control, 2'b00);
                check("idle_busy",  bus.busy, 1'b0);
                check("idle_ready", bus.port_ready, '0);
                for (int k = 1; k <= N && !m_active; k++) begin
                    p = (m_last + k) % N;
                    if (ctrl[p] != 2'b00) begin
                        m_active = 1'b1;
                        m_age    = 0;
                        m_port   = p;
                        m_read   = ctrl[p][1];
                        m_addr   = addr[p];
                        m_wdata  = wdata[p];
                        m_last   = p;
                    end
                end
            end else begin
                m_age++;
                ready_at  = m_read ? LAT + 2 : 2;
                exp_ctrl  = (m_age == 1) ? (m_read ? 2'b10 : 2'b01) : 2'b00;
                exp_ready = (m_age == ready_at) ? (N'(1) << m_port) : '0;
                if (m_age == ready_at && m_read) m_rdata = ram_val(m_addr);
                check("ram_ctrl", bus.ram_control, exp_ctrl);
                check("busy",     bus.busy, 1'b1);
                check("ready",    bus.port_ready, exp_ready);
                if (m_age == 1) begin
                    check("ram_addr",  bus.ram_address, m_addr);
                    check("ram_wdata", bus.ram_wdata, m_wdata);
                end
                if (m_age == ready_at) begin
                    grant_log.push_back(m_port);
                    m_active = 1'b0;
                end
            end
            check("port_rdata", bus.port_rdata, m_rdata);
        end
    end

    task automatic clear_ports();
        for (int i = 0; i < N; i++) begin
            ctrl[i]  = 2'b00;
            addr[i]  = '0;
            wdata[i] = '0;
        end
        drive();
    endtask

    task automatic settle();
        for (int i = 0; i < N; i++) ctrl[i] = 2'b00;
        drive();
        repeat (10) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    int exp3[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        reset = 1'b1;
        clear_ports();
        bus.ram_rdata = '0;
        repeat (3) tick();
        @(negedge clk);
        check("t0_busy",  bus.busy, 1'b0);
        check("t0_ready", bus.port_ready, '0);
        tick();
        reset = 1'b0;

        // Port 2 write: strobe at T+1, ready at T+2.
        ctrl[2] = 2'b01; addr[2] = 23'h10; wdata[2] = 32'hDEAD_BEEF;
        drive();
        @(negedge clk);
        @(negedge clk);
        check("t1_ctrl",  bus.ram_control, 2'b01);
        check("t1_addr",  bus.ram_address, 23'h10);
        check("t1_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_ready", bus.port_ready, 4'b0100);
        tick();
        settle();

        // Port 1 read with RAM latency 3: ready at T+5 carrying the RAM data.
        ctrl[1] = 2'b10; addr[1] = 23'h10; wdata[1] = 32'h0;
        drive();
        @(negedge clk);
        @(negedge clk);
        check("t2_ctrl", bus.ram_control, 2'b10);
        repeat (3) begin
            @(negedge clk);
            check("t2_early_ready", bus.port_ready, '0);
        end
        @(negedge clk);
        check("t2_ready", bus.port_ready, 4'b0010);
        check("t2_rdata", bus.port_rdata, 32'h1234_5678);
        tick();
        settle();

        // All ports requesting continuously from reset: strict rotation.
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            ctrl[i] = 2'b01; addr[i] = AW'(23'h100 + i); wdata[i] = DW'(32'hA0 + i);
        end
        drive();
        do_reset();
        for (int c = 0; c < 200 && grant_log.size() < 6; c++) @(negedge clk);
        check("t3_count", grant_log.size(), 6);
        if (grant_log.size() >= 6)
            for (int i = 0; i < 6; i++) check("t3_grant", grant_log[i], exp3[i]);
        tick();
        settle();

        // {1,1} is a read.
        ctrl[3] = 2'b11; addr[3] = 23'h20; wdata[3] = 32'hFFFF_0000;
        drive();
        @(negedge clk);
        @(negedge clk);
        check("t4_ctrl", bus.ram_control, 2'b10);
        tick();
        settle();

        // Reset in WAIT aborts at once; port 0 wins afterwards.
        ctrl[1] = 2'b10; addr[1] = 23'h30;
        drive();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("t5_ctrl",  bus.ram_control, 2'b00);
        check("t5_busy",  bus.busy, 1'b0);
        check("t5_ready", bus.port_ready, '0);
        grant_log.delete();
        for (int i = 0; i < N; i++) begin
            ctrl[i] = 2'b01; addr[i] = AW'(23'h200 + i); wdata[i] = DW'(32'hB0 + i);
        end
        drive();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 50 && grant_log.size() < 1; c++) @(negedge clk);
        check("t5_count", grant_log.size(), 1);
        if (grant_log.size() >= 1) check("t5_first", grant_log[0], 0);
        tick();
        settle();

        // Port 0 withdraws during WAIT: still completes, then no re-grant.
        ctrl[0] = 2'b10; addr[0] = 23'h40;
        drive();
        @(posedge clk);
        @(posedge clk);
        #1;
        ctrl[0] = 2'b00; addr[0] = 23'h7777;
        drive();
        repeat (4) @(negedge clk);
        check("t6_ready", bus.port_ready, 4'b0001);
        check("t6_rdata", bus.port_rdata, ram_val(23'h40));
        repeat (4) begin
            @(negedge clk);
            check("t6_idle", bus.busy, 1'b0);
        end
        tick();

        // Random traffic: ports request, hold until ready, then drop, repeat or renew.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (ctrl[i] == 2'b00 || rdy_seen[i]) begin
                    case ($urandom_range(0, 3))
                        0, 1: ctrl[i] = 2'b00;
                        2: begin
                            ctrl[i]  = 2'($urandom_range(1, 3));
                            addr[i]  = AW'($urandom);
                            wdata[i] = $urandom;
                        end
                        default: ;
                    endcase
                end
            end
            drive();
            tick();
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
